reg_file_mp: RTL and testbench

- Parametrised multi-port successor to the single-write, dual-read ULM register file.
- Features:
  - NUM_READ combinational read ports.
  - One write port with byte-masked merge.
  - Optional same-cycle write-to-read bypass.
  - Hardwired zero register.
  - Hardware clear engine that zeroes the whole array after reset or on request.
- Sits between decode (read addresses) and writeback (write port) in the ULM datapath.

---
 rtl/reg_file_mp_pkg.sv | 30 +++
 rtl/reg_file_mp_clear_fsm.sv | 58 +++++
 rtl/reg_file_mp.sv | 80 ++++++++
 tb/tb_reg_file_mp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types, defaults and the byte-merge helper for the multi-port register file.
package reg_file_mp_pkg;

  localparam int unsigned REG_WIDTH_DEF  = 64;
  localparam int unsigned REG_DEPTH_DEF  = 256;
  localparam int unsigned REG_ADDR_W_DEF = $clog2(REG_DEPTH_DEF);

  // Merge helper operates on a fixed wide word; callers widen and truncate.
  localparam int unsigned MERGE_W        = 512;
  localparam int unsigned MERGE_MASK_W   = MERGE_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } reg_clr_state_t;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]      old_w,
    input logic [MERGE_W-1:0]      new_w,
    input logic [MERGE_MASK_W-1:0] mask
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MERGE_MASK_W; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_mp_clear_fsm.sv
// Clear engine: sweeps every address once after reset or on request, then idles in READY.
module reg_clear_fsm
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned REG_DEPTH = REG_DEPTH_DEF,
  parameter int unsigned ADDR_W    = $clog2(REG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  reg_clr_state_t    state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // clr_req is only honoured from READY; requests during a sweep are dropped.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(REG_DEPTH - 1)) begin
          state_d    = READY;
          clr_addr_d = '0;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = clr_addr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_READ combinational reads, one byte-masked write,
// optional write-to-read bypass, optional hardwired zero register, hardware clear.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
  parameter int unsigned REG_DEPTH = REG_DEPTH_DEF,
  parameter int unsigned NUM_READ  = 3,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr_req,
  output logic                                 busy,
  input  logic                                 wr_en,
  input  logic [$clog2(REG_DEPTH)-1:0]         wr_addr,
  input  logic [REG_WIDTH-1:0]                 wr_data,
  input  logic [REG_WIDTH/8-1:0]               wr_mask,
  input  logic [NUM_READ*$clog2(REG_DEPTH)-1:0] rd_addr,
  output logic [NUM_READ*REG_WIDTH-1:0]        rd_data
);

  localparam int unsigned AW = $clog2(REG_DEPTH);

  logic [REG_WIDTH-1:0] mem_q [REG_DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_drop;
  logic          wr_ok;
  logic [REG_WIDTH-1:0] wr_merged;

  reg_clear_fsm #(
    .REG_DEPTH (REG_DEPTH),
    .ADDR_W    (AW)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_drop   = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok     = !busy && wr_en && !wr_drop;
  assign wr_merged = REG_WIDTH'(byte_merge(MERGE_W'(mem_q[wr_addr]),
                                           MERGE_W'(wr_data),
                                           MERGE_MASK_W'(wr_mask)));

  // Clear engine owns the write port while busy; user writes are silently dropped.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_merged;
    end
  end

  // Zero register beats bypass; everything reads 0 while the array is being cleared.
  always_comb begin
    logic [AW-1:0] ra;
    rd_data = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (busy) begin
        rd_data[k*REG_WIDTH +: REG_WIDTH] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[k*REG_WIDTH +: REG_WIDTH] = '0;
      end else if ((BYPASS != 0) && wr_ok && (ra == wr_addr)) begin
        rd_data[k*REG_WIDTH +: REG_WIDTH] = wr_merged;
      end else begin
        rd_data[k*REG_WIDTH +: REG_WIDTH] = mem_q[ra];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp; instance A uses defaults,
// instance B runs with BYPASS=0, ZERO_REG=0 on the same stimulus.
module tb_reg_file_mp;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 256;
  localparam int unsigned NR = 3;
  localparam int unsigned AW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr_req;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic [W/8-1:0]   wr_mask;
  logic [NR*AW-1:0] rd_addr;
  logic             busy_a, busy_b;
  logic [NR*W-1:0]  rd_data_a, rd_data_b;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [W-1:0] mem_a [D];
  logic [W-1:0] mem_b [D];
  int           busy_left;

  always #5 clk = ~clk;

  reg_file_mp dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_addr(rd_addr), .rd_data(rd_data_a)
  );

  reg_file_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_addr(rd_addr), .rd_data(rd_data_b)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] merged(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                          input logic [W/8-1:0] m);
    logic [W-1:0] bm;
    bm = '0;
    for (int i = 0; i < W/8; i++) if (m[i]) bm = bm | (64'hFF << (8*i));
    return (old_v & ~bm) | (new_v & bm);
  endfunction

  function automatic logic [W-1:0] port_of(input logic [NR*W-1:0] bus, input int k);
    return bus[k*W +: W];
  endfunction

  // Expected read value for instance A (bypass, zero reg) or B (neither).
  function automatic logic [W-1:0] exp_rd(input bit inst_b, input logic [AW-1:0] a);
    if (rst || busy_left > 0) return '0;
    if (!inst_b && a == '0) return '0;
    if (!inst_b && wr_en && a == wr_addr) return merged(mem_a[a], wr_data, wr_mask);
    return inst_b ? mem_b[a] : mem_a[a];
  endfunction

  task automatic zero_model();
    for (int i = 0; i < D; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  endtask

  task automatic settle();
    logic [AW-1:0] a;
    #1;
    if (rst) begin
      busy_left = D;
      zero_model();
    end
    check_eq("busy_a", W'(busy_a), W'(busy_left > 0));
    check_eq("busy_b", W'(busy_b), W'(busy_left > 0));
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      check_eq($sformatf("rd_a_p%0d", k), port_of(rd_data_a, k), exp_rd(1'b0, a));
      check_eq($sformatf("rd_b_p%0d", k), port_of(rd_data_b, k), exp_rd(1'b1, a));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      busy_left = D;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (clr_req) begin
      busy_left = D;
      zero_model();
    end else if (wr_en) begin
      if (wr_addr != '0) mem_a[wr_addr] = merged(mem_a[wr_addr], wr_data, wr_mask);
      mem_b[wr_addr] = merged(mem_b[wr_addr], wr_data, wr_mask);
    end
    @(negedge clk);
  endtask

  task automatic set_wr(input logic e, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [W/8-1:0] m);
    wr_en = e; wr_addr = a; wr_data = d; wr_mask = m;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      settle();
      if (!busy_a) break;
      n++;
      tick();
    end
    check_eq(tag, W'(n), W'(D));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_req = 1'b0; rd_addr = '0;
    set_wr(1'b0, '0, '0, '0);
    busy_left = D;
    zero_model();
    @(negedge clk);
    settle();
    check_eq("rst_busy", W'(busy_a), W'(1));
    tick();

    // Reset release: exactly D busy cycles, then everything reads 0.
    rst = 1'b0;
    set_rd(0, 8'h33); set_rd(1, 8'h80); set_rd(2, 8'hFF);
    count_clear("clr_len_rst");
    for (int k = 0; k < NR; k++) check_eq("post_clr_zero", port_of(rd_data_a, k), '0);
    tick();

    // Full then partial masked write.
    set_wr(1'b1, 8'd5, 64'h1122334455667788, 8'hFF);
    settle(); tick();
    set_wr(1'b0, '0, '0, '0);
    for (int k = 0; k < NR; k++) set_rd(k, 8'd5);
    settle();
    for (int k = 0; k < NR; k++) check_eq("t2_full", port_of(rd_data_a, k), 64'h1122334455667788);
    tick();
    set_wr(1'b1, 8'd5, {8{8'hAA}}, 8'h0F);
    settle(); tick();
    set_wr(1'b0, '0, '0, '0);
    settle();
    for (int k = 0; k < NR; k++) begin
      check_eq("t2_part_a", port_of(rd_data_a, k), 64'h11223344AAAAAAAA);
      check_eq("t2_part_b", port_of(rd_data_b, k), 64'h11223344AAAAAAAA);
    end
    tick();

    // Bypass vs no bypass.
    set_rd(0, 8'd7);
    set_wr(1'b1, 8'd7, 64'hDEAD, 8'h03);
    settle();
    check_eq("t3_byp_a", port_of(rd_data_a, 0), 64'hDEAD);
    check_eq("t3_nobyp_b", port_of(rd_data_b, 0), '0);
    tick();
    set_wr(1'b0, '0, '0, '0);
    settle();
    check_eq("t3_next_b", port_of(rd_data_b, 0), 64'hDEAD);
    tick();

    // Zero register.
    set_rd(1, 8'd0);
    set_wr(1'b1, 8'd0, '1, 8'hFF);
    settle();
    check_eq("t4_same_a", port_of(rd_data_a, 1), '0);
    check_eq("t4_same_b", port_of(rd_data_b, 1), '0);
    tick();
    set_wr(1'b0, '0, '0, '0);
    settle();
    check_eq("t4_next_a", port_of(rd_data_a, 1), '0);
    check_eq("t4_next_b", port_of(rd_data_b, 1), '1);
    tick();

    // Requested clear with a dropped write mid-sweep.
    for (int r = 1; r <= 3; r++) begin
      set_wr(1'b1, AW'(r), 64'h0101010101010101 * 64'(r), 8'hFF);
      settle(); tick();
    end
    set_wr(1'b0, '0, '0, '0);
    set_rd(0, 8'd1); set_rd(1, 8'd2); set_rd(2, 8'd3);
    clr_req = 1'b1;
    settle(); tick();
    clr_req = 1'b0;
    begin
      int n;
      n = 0;
      for (int i = 0; i < 400; i++) begin
        set_wr(n == 50, 8'd2, '1, 8'hFF);
        settle();
        if (!busy_a) break;
        n++;
        tick();
      end
      check_eq("clr_len_req", W'(n), W'(D));
    end
    set_wr(1'b0, '0, '0, '0);
    settle();
    for (int k = 0; k < NR; k++) check_eq("t5_cleared", port_of(rd_data_a, k), '0);
    tick();

    // Reset during a requested clear restarts the full sweep.
    clr_req = 1'b1;
    settle(); tick();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) begin settle(); tick(); end
    rst = 1'b1;
    settle();
    check_eq("t6_rst_busy", W'(busy_a), W'(1));
    tick();
    rst = 1'b0;
    count_clear("clr_len_restart");
    tick();

    // Random traffic over a small address window to hit bypass and overlap often.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 1499) == 0);
      clr_req = ($urandom_range(0, 799) == 0);
      set_wr(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
             {$urandom(), $urandom()}, 8'($urandom()));
      for (int k = 0; k < NR; k++)
        set_rd(k, $urandom_range(0, 1) ? wr_addr : AW'($urandom_range(0, 15)));
      settle();
      tick();
    end
    rst = 1'b0; clr_req = 1'b0;
    set_wr(1'b0, '0, '0, '0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
